uart_rx: RTL and testbench

- UART receiver, 8N1, LSB first, 16x oversampling. Sits directly downstream of the top_uart transmitter.
- Consumes the serial line (o_txd in loopback, or the external RX pin).
- Delivers each received byte with a 1-cycle done strobe, mirroring the transmitter's start/done style.
- Flags framing errors.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/baud_tick_gen.sv | 33 +++
 rtl/uart_rx.sv | 130 +++++++++++++
 tb/tb_uart_rx.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame constants
// and the oversampled baud divider used by both TX and RX.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  function automatic int calc_div(
    input int clk_freq,
    input int baud,
    input int os
  );
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick: one clk pulse every DIV clocks.
// Shared by the UART transmitter and receiver.
module baud_tick_gen #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int DIV =
    uart_pkg::calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt    <= '0;
      o_tick <= 1'b1;
    end else begin
      cnt    <= cnt + 1'b1;
      o_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, 16x oversampling,
// with single-cycle done / framing-error strobes.
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rxd,
  output logic [7:0] o_rx_data,
  output logic       o_rx_done,
  output logic       o_frame_err,
  output logic       o_busy
);

  import uart_pkg::*;

  logic                 sync0;
  logic                 rx_s;
  logic [1:0]           sync_fill;
  logic                 armed;
  logic                 tick;
  rx_state_e            state;
  logic [3:0]           tick_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  baud_tick_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .o_tick (tick)
  );

  // sync_fill marks when rx_s holds a real line sample,
  // so the reset value of the synchronizer cannot arm us.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0     <= 1'b1;
      rx_s      <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      sync0     <= i_rxd;
      rx_s      <= sync0;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      armed       <= 1'b0;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      o_rx_data   <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
      if (rx_s && sync_fill[1]) armed <= 1'b1;
      unique case (state)
        IDLE: begin
          if (armed && !rx_s) begin
            state    <= START;
            tick_cnt <= '0;
            o_busy   <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == 4'd7) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state  <= IDLE;
                o_busy <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == 4'd15) begin
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
              tick_cnt  <= '0;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'(DATA_BITS - 1)) state <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt == 4'd15) begin
              tick_cnt <= '0;
              state    <= IDLE;
              o_busy   <= 1'b0;
              if (rx_s) begin
                o_rx_data <= shift_reg;
                o_rx_done <= 1'b1;
              end else begin
                o_frame_err <= 1'b1;
                armed       <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a scaled baud rate
// (DIV=4, 64 clk per bit) so frames stay short.
module tb_uart_rx;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 1_562_500;
  localparam int BIT_NS   = 640;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  int tests;
  int fails;

  int        done_cnt;
  int        err_cnt;
  int        busy_cnt;
  logic [7:0] dq [$];
  longint    last_done_t;

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_rxd       (rxd),
    .o_rx_data   (rx_data),
    .o_rx_done   (rx_done),
    .o_frame_err (frame_err),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    done_cnt    = 0;
    err_cnt     = 0;
    busy_cnt    = 0;
    last_done_t = 0;
  end

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt    = done_cnt + 1;
      last_done_t = $time;
      dq.push_back(rx_data);
    end
    if (frame_err) err_cnt = err_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic send_byte(input logic [7:0] b,
                           input logic stop);
    rxd = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #BIT_NS;
    end
    rxd = stop;
    #BIT_NS;
  endtask

  task automatic test_reset();
    #23;
    tests++;
    if (rx_data !== 8'h00) begin
      fails++;
      $display("FAIL rst_data: got %h want 00", rx_data);
    end
    tests++;
    if (rx_done !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_pulses: got %b%b want 00",
               rx_done, frame_err);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_busy: got %b want 0", busy);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done_cnt !== 0) begin
      fails++;
      $display("FAIL post_rst_idle: busy %b done %0d want 0 0",
               busy, done_cnt);
    end
  endtask

  task automatic test_single();
    int     d0;
    int     e0;
    longint t0;
    longint lat;
    d0 = done_cnt;
    e0 = err_cnt;
    t0 = $time;
    send_byte(8'hA3, 1'b1);
    tests++;
    if (done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL single_done_cnt: got %0d want 1",
               done_cnt - d0);
    end
    tests++;
    if (rx_data !== 8'hA3) begin
      fails++;
      $display("FAIL single_data: got %h want a3", rx_data);
    end
    tests++;
    if (err_cnt - e0 !== 0) begin
      fails++;
      $display("FAIL single_err: got %0d want 0", err_cnt - e0);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL single_busy: got %b want 0", busy);
    end
    lat = last_done_t - t0;
    tests++;
    if (lat < 6040 || lat > 6160) begin
      fails++;
      $display("FAIL single_latency: got %0d ns want 6040..6160",
               lat);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = dq.size();
    send_byte(8'hA3, 1'b1);
    send_byte(8'hAF, 1'b1);
    #BIT_NS;
    tests++;
    if (dq.size() - n0 !== 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d want 2", dq.size() - n0);
    end else begin
      tests++;
      if (dq[n0] !== 8'hA3) begin
        fails++;
        $display("FAIL b2b_first: got %h want a3", dq[n0]);
      end
      tests++;
      if (dq[n0+1] !== 8'hAF) begin
        fails++;
        $display("FAIL b2b_second: got %h want af", dq[n0+1]);
      end
    end
  endtask

  task automatic test_glitch();
    int d0;
    int e0;
    int b0;
    d0 = done_cnt;
    e0 = err_cnt;
    b0 = busy_cnt;
    rxd = 1'b0;
    #20;
    rxd = 1'b1;
    #(2 * BIT_NS);
    tests++;
    if (busy_cnt - b0 <= 0) begin
      fails++;
      $display("FAIL glitch_busy_seen: got %0d cycles want >0",
               busy_cnt - b0);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL glitch_busy_end: got %b want 0", busy);
    end
    tests++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
      fails++;
      $display("FAIL glitch_pulses: done %0d err %0d want 0 0",
               done_cnt - d0, err_cnt - e0);
    end
    tests++;
    if (rx_data !== 8'hAF) begin
      fails++;
      $display("FAIL glitch_data: got %h want af", rx_data);
    end
  endtask

  task automatic test_frame_err();
    int d0;
    int e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'h55, 1'b0);
    rxd = 1'b1;
    #(2 * BIT_NS);
    tests++;
    if (err_cnt - e0 !== 1) begin
      fails++;
      $display("FAIL ferr_count: got %0d want 1", err_cnt - e0);
    end
    tests++;
    if (done_cnt - d0 !== 0) begin
      fails++;
      $display("FAIL ferr_no_done: got %0d want 0",
               done_cnt - d0);
    end
    tests++;
    if (rx_data !== 8'hAF) begin
      fails++;
      $display("FAIL ferr_hold: got %h want af", rx_data);
    end
    send_byte(8'h0F, 1'b1);
    tests++;
    if (rx_data !== 8'h0F || done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL ferr_next: got %h/%0d want 0f/1",
               rx_data, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    int e0;
    logic [7:0] b;
    b  = 8'h0F;
    d0 = done_cnt;
    e0 = err_cnt;
    rxd = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      #BIT_NS;
    end
    rxd = b[4];
    #300;
    reset = 1'b1;
    #1;
    tests++;
    if (rx_data !== 8'h00 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midrst_async: data %h busy %b want 00 0",
               rx_data, busy);
    end
    tests++;
    if (rx_done !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL midrst_pulses: got %b%b want 00",
               rx_done, frame_err);
    end
    #49;
    reset = 1'b0;
    #(BIT_NS - 350);
    for (int i = 5; i < 8; i++) begin
      rxd = b[i];
      #BIT_NS;
    end
    rxd = 1'b1;
    #(2 * BIT_NS);
    tests++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
      fails++;
      $display("FAIL midrst_tail: done %0d err %0d want 0 0",
               done_cnt - d0, err_cnt - e0);
    end
    send_byte(8'h3C, 1'b1);
    tests++;
    if (rx_data !== 8'h3C || done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL midrst_next: got %h/%0d want 3c/1",
               rx_data, done_cnt - d0);
    end
  endtask

  task automatic test_loopback_vectors();
    logic [7:0] v [3];
    int d0;
    v = '{8'h00, 8'hFF, 8'hA3};
    for (int k = 0; k < 3; k++) begin
      d0 = done_cnt;
      send_byte(v[k], 1'b1);
      #BIT_NS;
      tests++;
      if (done_cnt - d0 !== 1) begin
        fails++;
        $display("FAIL vec%0d_done: got %0d want 1",
                 k, done_cnt - d0);
      end
      tests++;
      if (rx_data !== v[k]) begin
        fails++;
        $display("FAIL vec%0d_data: got %h want %h",
                 k, rx_data, v[k]);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rxd   = 1'b1;
    reset = 1'b1;
    test_reset();
    @(negedge clk);
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_loopback_vectors();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
